// File: rtl/pt2262_pkg.sv
// ---------------------------------------------------------------------------
// pt2262_pkg
// Shared types and constants for the PT2262 transmit scheduler.
//   sched_state_t : scheduler FSM states
//   FRAME_OSC     : encoder oscillator periods per frame (12 x 32 + 128)
//   CLK_PER_OSC   : 3 MHz clk cycles per encoder oscillator period
//   FRAME_CLK     : clk cycles per complete encoder frame
// ---------------------------------------------------------------------------
package pt2262_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ARM  = 2'd2,
        SEND = 2'd3
    } sched_state_t;

    localparam int FRAME_OSC   = 512;
    localparam int CLK_PER_OSC = 250;
    localparam int FRAME_CLK   = FRAME_OSC * CLK_PER_OSC;

endpackage

// File: rtl/pt2262_tx_scheduler_arbiter.sv
// ---------------------------------------------------------------------------
// pt_rr_arbiter
// Round-robin arbiter. The search starts at the index held in the pointer
// register; after a grant the pointer moves to the winner + 1 (mod NREQ).
// Ports:
//   clk, reset    : clock, asynchronous active-high reset (pointer -> 0)
//   i_req         : request vector
//   i_advance     : a grant is being taken this cycle; update the pointer
//   o_grant       : one-hot grant (combinational)
//   o_grant_idx   : index of the granted requester (combinational)
// ---------------------------------------------------------------------------
module pt_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_advance,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_grant_idx
);

    logic [IDW-1:0]  r_ptr;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;
    logic            w_found;

    // Walk the requesters starting at the pointer and wrap around; the
    // first active one wins. The sum carries one extra bit so the wrap
    // test works for non power-of-two NREQ.
    always_comb begin
        logic [IDW:0] w_sum;
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ))
                w_sum = w_sum - (IDW+1)'(NREQ);
            if (!w_found && i_req[w_sum[IDW-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_sum[IDW-1:0];
            end
        end
        w_grant[w_idx] = w_found;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ptr <= '0;
        else if (i_advance && w_found)
            r_ptr <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + IDW'(1);
    end

    assign o_grant     = w_grant;
    assign o_grant_idx = w_idx;

endmodule

// File: rtl/pt2262_tx_scheduler.sv
// ---------------------------------------------------------------------------
// pt2262_tx_scheduler
// Transmit scheduler in front of the PT2262 encoder. Arbitrates NREQ
// requesters round-robin, loads the winner's address/data into the encoder
// only while the encoder is in its SYNC symbol, gates REPEATS whole frames
// onto the RF path and then pulses tx_done.
// Optional feature macro: PT_SCHED_HOLD_EN (adds req_hold; a held requester
// keeps the gate open beyond REPEATS frames).
// Ports:
//   clk, reset            : 3 MHz clock, asynchronous active-high reset
//   req_valid/addr/data   : requester words (addr[8i+:8], data[4i+:4])
//   req_ready             : one-hot accept pulse, only in IDLE
//   enc_sync              : encoder sync output (asynchronous)
//   enc_a, enc_d          : encoder A/D inputs
//   tx_gate               : high across the scheduled frames
//   busy                  : FSM not in IDLE
//   tx_done               : 1-cycle pulse after the last gated frame
//   tx_id                 : index of the requester being or last served
//   req_hold (optional)   : extend transmission of the current requester
// ---------------------------------------------------------------------------
module pt2262_tx_scheduler
    import pt2262_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int REPEATS = 4,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_addr,
    input  logic [NREQ*4-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic              enc_sync,
`ifdef PT_SCHED_HOLD_EN
    input  logic [NREQ-1:0]   req_hold,
`endif
    output logic [7:0]        enc_a,
    output logic [3:0]        enc_d,
    output logic              tx_gate,
    output logic              busy,
    output logic              tx_done,
    output logic [IDW-1:0]    tx_id
);

    localparam logic [3:0] LAST_FRAME = 4'(REPEATS - 1);

    sched_state_t r_state;
    logic         r_sync1, r_sync2, r_sync3;
    logic [7:0]   r_shadow_a, r_enc_a;
    logic [3:0]   r_shadow_d, r_enc_d;
    logic [3:0]   r_fcnt;
    logic         r_tx_gate, r_tx_done;
    logic [IDW-1:0] r_tx_id;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gidx;
    logic            w_idle, w_any_req, w_sr, w_sf, w_hold;
    logic [7:0]      w_addr_arr [NREQ];
    logic [3:0]      w_data_arr [NREQ];

    // Unpack the flattened payload buses so the winner can be indexed.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_addr_arr[gi] = req_addr[8*gi +: 8];
            assign w_data_arr[gi] = req_data[4*gi +: 4];
        end
    endgenerate

    assign w_idle    = (r_state == IDLE);
    assign w_any_req = |req_valid;

    // Edge strobes on the synchronized sync (r_sync2), r_sync3 is its history.
    assign w_sr = r_sync2 & ~r_sync3;
    assign w_sf = ~r_sync2 & r_sync3;

`ifdef PT_SCHED_HOLD_EN
    assign w_hold = req_hold[r_tx_id];
`else
    assign w_hold = 1'b0;
`endif

    pt_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_req       (req_valid),
        .i_advance   (w_idle),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx)
    );

    // The accept pulse must coincide with the cycle the grant is taken,
    // so it is decoded directly from the IDLE state and the arbiter.
    assign req_ready = w_idle ? w_grant : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync3    <= 1'b0;
            r_shadow_a <= '0;
            r_shadow_d <= '0;
            r_enc_a    <= '0;
            r_enc_d    <= '0;
            r_fcnt     <= '0;
            r_tx_gate  <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_id    <= '0;
        end else begin
            r_sync1   <= enc_sync;
            r_sync2   <= r_sync1;
            r_sync3   <= r_sync2;
            r_tx_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A sync rise in this same cycle is deliberately not
                    // consumed: LOAD waits for the next one.
                    if (w_any_req) begin
                        r_shadow_a <= w_addr_arr[w_gidx];
                        r_shadow_d <= w_data_arr[w_gidx];
                        r_tx_id    <= w_gidx;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    // Encoder ignores A/D during SYNC, so updating here is safe.
                    if (w_sr) begin
                        r_enc_a <= r_shadow_a;
                        r_enc_d <= r_shadow_d;
                        r_state <= ARM;
                    end
                end
                ARM: begin
                    if (w_sf) begin
                        r_tx_gate <= 1'b1;
                        r_fcnt    <= '0;
                        r_state   <= SEND;
                    end
                end
                SEND: begin
                    if (w_sf) begin
                        if (r_fcnt == LAST_FRAME) begin
                            // Held requester: counter stays saturated.
                            if (!w_hold) begin
                                r_tx_gate <= 1'b0;
                                r_tx_done <= 1'b1;
                                r_state   <= IDLE;
                            end
                        end else begin
                            r_fcnt <= r_fcnt + 4'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign enc_a   = r_enc_a;
    assign enc_d   = r_enc_d;
    assign tx_gate = r_tx_gate;
    assign tx_done = r_tx_done;
    assign tx_id   = r_tx_id;
    assign busy    = ~w_idle;

endmodule

// File: tb/tb_pt2262_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pt2262_tx_scheduler
// Directed bench for pt2262_tx_scheduler with a stub sync generator
// (40-clk frames, sync high for 8 clk). Define PT_SCHED_HOLD_EN to also
// exercise the hold extension.
// ---------------------------------------------------------------------------
module tb_pt2262_tx_scheduler;

    localparam int PERIOD = 40;
    localparam int GATE4  = 4 * PERIOD;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_addr;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        enc_sync;
`ifdef PT_SCHED_HOLD_EN
    logic [3:0]  req_hold;
`endif
    logic [7:0]  enc_a;
    logic [3:0]  enc_d;
    logic        tx_gate, busy, tx_done;
    logic [1:0]  tx_id;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    bit gen_en = 1'b0;
    bit mon_en = 1'b0;

    // bench view of the synchronized sync
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_s3 = 1'b0;
    logic [11:0] p_ad = '0;
    logic p_gate = 1'b0, p_sr = 1'b0, p_sf = 1'b0, p_reset = 1'b1;

    pt2262_tx_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .enc_sync  (enc_sync),
`ifdef PT_SCHED_HOLD_EN
        .req_hold  (req_hold),
`endif
        .enc_a     (enc_a),
        .enc_d     (enc_d),
        .tx_gate   (tx_gate),
        .busy      (busy),
        .tx_done   (tx_done),
        .tx_id     (tx_id)
    );

    always #5 clk = ~clk;

    // stub sync generator, changes away from the active edge
    initial begin
        int sg_cnt;
        sg_cnt = 0;
        enc_sync = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (gen_en) begin
                enc_sync = (sg_cnt < 8);
                sg_cnt = (sg_cnt == PERIOD - 1) ? 0 : sg_cnt + 1;
            end else begin
                enc_sync = 1'b0;
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1 <= 1'b0; m_s2 <= 1'b0; m_s3 <= 1'b0;
        end else begin
            m_s1 <= enc_sync; m_s2 <= m_s1; m_s3 <= m_s2;
        end
    end

    // A/D may only change after a sync rise strobe; gate only after a fall strobe.
    always @(negedge clk) begin
        if (mon_en && !reset && !p_reset) begin
            if ({enc_a, enc_d} !== p_ad) begin
                total++;
                if (!p_sr) begin
                    bad++;
                    $display("FAIL mon_ad_change: a/d changed to %h/%h without sync rise", enc_a, enc_d);
                end
            end
            if (tx_gate !== p_gate) begin
                total++;
                if (!p_sf) begin
                    bad++;
                    $display("FAIL mon_gate_edge: tx_gate went %b without sync fall", tx_gate);
                end
            end
        end
        if (tx_done === 1'b1) done_cnt++;
        p_ad    = {enc_a, enc_d};
        p_gate  = tx_gate;
        p_sr    = m_s2 & ~m_s3;
        p_sf    = ~m_s2 & m_s3;
        p_reset = reset;
    end

    // Wait for the current service to finish; check gate width, payload, id.
    task automatic wait_serve(input string nm, input int exp_gate, input logic [1:0] exp_id,
                              input logic [7:0] exp_a, input logic [3:0] exp_d);
        int n, gate_cyc;
        logic prev_g;
        n = 0; gate_cyc = 0; prev_g = tx_gate;
        do begin
            @(negedge clk);
            n++;
            if (tx_gate === 1'b1) gate_cyc++;
            if (tx_gate === 1'b1 && prev_g !== 1'b1) begin
                total++;
                if (enc_a !== exp_a || enc_d !== exp_d) begin
                    bad++;
                    $display("FAIL %s_payload: got %h/%h want %h/%h", nm, enc_a, enc_d, exp_a, exp_d);
                end
            end
            prev_g = tx_gate;
        end while (tx_done !== 1'b1 && n < 3000);
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL %s_timeout: no tx_done within %0d cycles", nm, n);
        end
        total++;
        if (gate_cyc !== exp_gate) begin
            bad++;
            $display("FAIL %s_gate_len: got %0d want %0d", nm, gate_cyc, exp_gate);
        end
        total++;
        if (tx_id !== exp_id || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_end: tx_id=%0d busy=%b want tx_id=%0d busy=0", nm, tx_id, busy, exp_id);
        end
        $display("serve %s: id=%0d gate_cycles=%0d", nm, tx_id, gate_cyc);
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
`ifdef PT_SCHED_HOLD_EN
        req_hold = '0;
`endif
        #2 reset = 1'b1;
        #1;
        total++;
        if ({req_ready, enc_a, enc_d, tx_gate, busy, tx_done, tx_id} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: rdy=%b a=%h d=%h g=%b b=%b dn=%b id=%0d want all 0",
                     req_ready, enc_a, enc_d, tx_gate, busy, tx_done, tx_id);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        gen_en = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || tx_gate !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: busy=%b gate=%b want 0/0", busy, tx_gate);
        end
        $display("reset: outputs idle");
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 4'b0100;
        req_addr  = 32'h00A5_0000;
        req_data  = 16'h0900;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        total++;
        if (busy !== 1'b1 || tx_id !== 2'd2 || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL single_grant: busy=%b id=%0d rdy=%b want 1/2/0000", busy, tx_id, req_ready);
        end
        wait_serve("single", GATE4, 2'd2, 8'hA5, 4'h9);
        @(negedge clk);
        total++;
        if (tx_done !== 1'b0) begin
            bad++;
            $display("FAIL single_done_pulse: tx_done=%b want 0", tx_done);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] order [5];
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_addr  = 32'h1312_1110;
        req_data  = 16'hFEDC;
        req_valid = 4'b1111;
        #1;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] exp_rdy;
            exp_rdy = 4'b0001 << order[i];
            total++;
            if (req_ready !== exp_rdy) begin
                bad++;
                $display("FAIL rr_order_%0d: ready=%b want %b", i, req_ready, exp_rdy);
            end
            if (i == 4) begin
                @(negedge clk);
                req_valid = '0;
            end
            wait_serve($sformatf("rr%0d", i), GATE4, order[i],
                       8'h10 + 8'(order[i]), 4'hC + 4'(order[i]));
        end
    endtask

    task automatic test_reset_mid();
        int n, d0;
        @(negedge clk);
        req_valid = 4'b0010;
        req_addr  = 32'h0000_3C00;
        req_data  = 16'h0060;
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (tx_gate !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        n = 0;
        while (!(~m_s2 & m_s3) && n < 500) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        d0 = done_cnt;
        #2 reset = 1'b1;
        #1;
        total++;
        if (tx_gate !== 1'b0 || busy !== 1'b0 || enc_a !== 8'h00 || tx_done !== 1'b0) begin
            bad++;
            $display("FAIL midreset_drop: gate=%b busy=%b a=%h done=%b want 0/0/00/0",
                     tx_gate, busy, enc_a, tx_done);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        total++;
        if (done_cnt !== d0) begin
            bad++;
            $display("FAIL midreset_no_done: tx_done pulses=%0d want 0", done_cnt - d0);
        end
        req_valid = 4'b1000;
        req_addr  = 32'h7700_0000;
        req_data  = 16'h2000;
        #1;
        total++;
        if (req_ready !== 4'b1000) begin
            bad++;
            $display("FAIL midreset_regrant: ready=%b want 1000", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        wait_serve("after_reset", GATE4, 2'd3, 8'h77, 4'h2);
    endtask

    task automatic test_same_cycle_sr();
        int n;
        n = 0;
        @(negedge clk);
        while (!(m_s2 & ~m_s3) && n < 200) begin @(negedge clk); n++; end
        req_valid = 4'b0001;
        req_addr  = 32'h0000_00E1;
        req_data  = 16'h0004;
        #1;
        total++;
        if (req_ready !== 4'b0001 || !(m_s2 & ~m_s3)) begin
            bad++;
            $display("FAIL samesr_grant: ready=%b sr=%b want 0001/1", req_ready, m_s2 & ~m_s3);
        end
        n = 0;
        @(negedge clk);
        n++;
        req_valid = '0;
        total++;
        if (enc_a !== 8'h77) begin
            bad++;
            $display("FAIL samesr_no_early_load: enc_a=%h want 77", enc_a);
        end
        while (enc_a !== 8'hE1 && n < 200) begin @(negedge clk); n++; end
        total++;
        if (n !== PERIOD + 1) begin
            bad++;
            $display("FAIL samesr_load_delay: load after %0d cycles want %0d", n, PERIOD + 1);
        end
        $display("same-cycle sr: load after %0d cycles", n);
        wait_serve("samesr", GATE4, 2'd0, 8'hE1, 4'h4);
    endtask

`ifdef PT_SCHED_HOLD_EN
    task automatic test_hold();
        int n, sfc, gate_cyc;
        @(negedge clk);
        req_valid = 4'b0010;
        req_addr  = 32'h0000_5A00;
        req_data  = 16'h00B0;
        req_hold  = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        n = 0; sfc = 0; gate_cyc = 0;
        do begin
            @(negedge clk);
            n++;
            if (tx_gate === 1'b1) begin
                gate_cyc++;
                if (~m_s2 & m_s3) sfc++;
                else if (sfc == 6) req_hold = '0;
            end
        end while (tx_done !== 1'b1 && n < 3000);
        total++;
        if (gate_cyc !== 7 * PERIOD || tx_id !== 2'd1) begin
            bad++;
            $display("FAIL hold_len: gate=%0d id=%0d want %0d/1", gate_cyc, tx_id, 7 * PERIOD);
        end
        $display("hold: gate_cycles=%0d frames_seen=%0d", gate_cyc, sfc);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_reset_mid();
        test_same_cycle_sr();
`ifdef PT_SCHED_HOLD_EN
        test_hold();
`endif
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
